// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a variable-latency memory
// handshake and hands the IR to decode. Optional halt detection: IFU_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter int                 INSTR_W  = 24,
  parameter int                 PC_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC = {PC_W{1'b0}},
  parameter int                 PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef IFU_HALT_DETECT_EN
  output logic               halted,
`endif
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    FLUSH  = 2'd2
`ifdef IFU_HALT_DETECT_EN
    , HALTED = 2'd3
`endif
  } state_t;

  state_t            state_r;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_next_s;

  assign pc_next_s = pc_r + PC_W'(PC_STEP);
  assign imem_addr = pc_r;
  assign opcode    = instr[INSTR_W-1 -: 4];

  // Fetch FSM with PC, IR and handshake outputs all held in registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= {INSTR_W{1'b0}};
      instr_pc    <= {PC_W{1'b0}};
      instr_valid <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state_r)
        FETCH: begin
          if (redirect) begin
            pc_r        <= redirect_pc;
            instr_valid <= 1'b0;
            // An unanswered request must be drained before refetching.
            if (imem_valid || !imem_req) begin
              state_r  <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state_r  <= FLUSH;
              imem_req <= 1'b0;
            end
          end else if (imem_valid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc_r;
            pc_r        <= pc_next_s;
            instr_valid <= 1'b1;
            state_r     <= HOLD;
            imem_req    <= 1'b0;
          end else begin
            imem_req <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_r        <= redirect_pc;
            instr_valid <= 1'b0;
            state_r     <= FETCH;
            imem_req    <= 1'b1;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
`ifdef IFU_HALT_DETECT_EN
            if (opcode == 4'b1111) begin
              state_r  <= HALTED;
              imem_req <= 1'b0;
              halted   <= 1'b1;
            end else begin
              state_r  <= FETCH;
              imem_req <= 1'b1;
            end
`else
            state_r  <= FETCH;
            imem_req <= 1'b1;
`endif
          end else begin
            imem_req <= 1'b0;
          end
        end

        FLUSH: begin
          instr_valid <= 1'b0;
          if (redirect) begin
            pc_r <= redirect_pc;
          end else begin
            pc_r <= pc_r;
          end
          // The stale response is always swallowed, even alongside a redirect.
          if (imem_valid) begin
            state_r  <= FETCH;
            imem_req <= 1'b1;
          end else begin
            imem_req <= 1'b0;
          end
        end

`ifdef IFU_HALT_DETECT_EN
        HALTED: begin
          instr_valid <= 1'b0;
          if (redirect) begin
            pc_r     <= redirect_pc;
            state_r  <= FETCH;
            imem_req <= 1'b1;
            halted   <= 1'b0;
          end else begin
            imem_req <= 1'b0;
          end
        end
`endif

        default: begin
          state_r     <= FETCH;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [23:0] imem_rdata;
  logic        imem_valid;
  logic [23:0] instr;
  logic [3:0]  opcode;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef IFU_HALT_DETECT_EN
  logic        halted;
`endif

  int total = 0;
  int bad   = 0;

  int   mem_lat;
  logic mem_pend;
  int   mem_cnt;
  logic [23:0] mem_word;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_W (24),
    .PC_W    (16),
    .RESET_PC(16'h0010),
    .PC_STEP (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instr      (instr),
    .opcode     (opcode),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
`ifdef IFU_HALT_DETECT_EN
    .halted     (halted),
`endif
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  // Memory: answers mem_lat cycles after the request cycle (0 = same cycle).
  assign imem_valid = (mem_pend && mem_cnt == 0) || (!mem_pend && imem_req && mem_lat == 0);
  assign imem_rdata = mem_word;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else if (!mem_pend && imem_req && mem_lat != 0) begin
      mem_pend <= 1'b1;
      mem_cnt  <= mem_lat - 1;
    end else if (mem_pend && mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end else if (mem_pend) begin
      mem_pend <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    mem_lat     = 0;
    mem_word    = 24'h612345;
    tick();
    tick();
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_instr", {8'd0, instr},        32'd0);
    check("rst_ipc",   {16'd0, instr_pc},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_addr",  {16'd0, imem_addr},   32'h0010);
    rst_n = 1'b1;

    // Zero-wait first fetch
    tick();
    check("f1_req",  {31'd0, imem_req},  32'd1);
    check("f1_addr", {16'd0, imem_addr}, 32'h0010);
    tick();
    check("f1_instr",  {8'd0, instr},        32'h612345);
    check("f1_opcode", {28'd0, opcode},      32'h6);
    check("f1_ipc",    {16'd0, instr_pc},    32'h0010);
    check("f1_valid",  {31'd0, instr_valid}, 32'd1);
    check("f1_reqlow", {31'd0, imem_req},    32'd0);

    // Stall in HOLD, then 3-cycle memory
    mem_lat = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", {8'd0, instr},        32'h612345);
      check("hold_req",   {31'd0, imem_req},    32'd0);
      check("hold_pc",    {16'd0, imem_addr},   32'h0011);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    mem_word    = 24'hA00011;
    check("acc_valid", {31'd0, instr_valid}, 32'd0);
    check("acc_req",   {31'd0, imem_req},    32'd1);
    check("acc_addr",  {16'd0, imem_addr},   32'h0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lat_valid", {31'd0, instr_valid}, 32'd0);
      check("lat_req",   {31'd0, imem_req},    32'd1);
    end
    tick();
    check("lat_instr", {8'd0, instr},        32'hA00011);
    check("lat_ipc",   {16'd0, instr_pc},    32'h0011);
    check("lat_ival",  {31'd0, instr_valid}, 32'd1);

    // Redirect with a request outstanding: FLUSH and discard
    instr_ready = 1'b1;
    mem_word    = 24'h0BAD00;
    tick();
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    check("fl_req",   {31'd0, imem_req},    32'd0);
    check("fl_valid", {31'd0, instr_valid}, 32'd0);
    check("fl_addr",  {16'd0, imem_addr},   32'h0200);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fl_wreq", {31'd0, imem_req},    32'd0);
      check("fl_wval", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    check("fl_dval", {31'd0, instr_valid}, 32'd0);
    check("fl_nreq", {31'd0, imem_req},    32'd1);
    check("fl_naddr", {16'd0, imem_addr},  32'h0200);
    mem_word = 24'h200200;
    for (int i = 0; i < 4; i++) tick();
    check("fl_instr", {8'd0, instr},        32'h200200);
    check("fl_ipc",   {16'd0, instr_pc},    32'h0200);
    check("fl_ival",  {31'd0, instr_valid}, 32'd1);
    mem_lat = 0;

    // Redirect together with instr_ready in HOLD
    redirect    = 1'b1;
    redirect_pc = 16'h0300;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    mem_word    = 24'h300300;
    check("rh_valid", {31'd0, instr_valid}, 32'd0);
    check("rh_req",   {31'd0, imem_req},    32'd1);
    check("rh_addr",  {16'd0, imem_addr},   32'h0300);
    check("rh_irkeep", {8'd0, instr},       32'h200200);
    tick();
    check("rh_instr", {8'd0, instr},     32'h300300);
    check("rh_ipc",   {16'd0, instr_pc}, 32'h0300);

    // PC wrap at 0xFFFF
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    mem_word = 24'h5ABCDE;
    check("wr_addr", {16'd0, imem_addr}, 32'hFFFF);
    tick();
    check("wr_ipc",  {16'd0, instr_pc},  32'hFFFF);
    check("wr_pc",   {16'd0, imem_addr}, 32'h0000);
    check("wr_ival", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wr_req",   {31'd0, imem_req},  32'd1);
    check("wr_naddr", {16'd0, imem_addr}, 32'h0000);

    // Redirect in FETCH coinciding with the response
    redirect    = 1'b1;
    redirect_pc = 16'h0400;
    tick();
    redirect = 1'b0;
    mem_word = 24'h400400;
    check("rv_valid", {31'd0, instr_valid}, 32'd0);
    check("rv_req",   {31'd0, imem_req},    32'd1);
    check("rv_addr",  {16'd0, imem_addr},   32'h0400);
    tick();
    check("rv_instr", {8'd0, instr},     32'h400400);
    check("rv_ipc",   {16'd0, instr_pc}, 32'h0400);

    // Opcode 4'b1111 accepted
    instr_ready = 1'b1;
    mem_word    = 24'hF00000;
    tick();
    tick();
    check("h_op",   {28'd0, opcode},      32'hF);
    check("h_ival", {31'd0, instr_valid}, 32'd1);
    tick();
    instr_ready = 1'b0;
`ifdef IFU_HALT_DETECT_EN
    check("h_halted", {31'd0, halted},      32'd1);
    check("h_req",    {31'd0, imem_req},    32'd0);
    check("h_valid",  {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("h_stay_req", {31'd0, imem_req}, 32'd0);
      check("h_stay_hlt", {31'd0, halted},   32'd1);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("h_exit_hlt",  {31'd0, halted},    32'd0);
    check("h_exit_req",  {31'd0, imem_req},  32'd1);
    check("h_exit_addr", {16'd0, imem_addr}, 32'h0040);
`else
    check("nh_req",   {31'd0, imem_req},    32'd1);
    check("nh_addr",  {16'd0, imem_addr},   32'h0402);
    check("nh_valid", {31'd0, instr_valid}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
